// File: rtl/rr_encoder32_5_if.sv
// Handshake bundle for rr_encoder32_5: request vector in, registered index out.
// RR_ENC_REQ_COUNT_EN adds the req_cnt popcount output.
interface rr_encoder32_5_if #(
    parameter int N = 32,
    parameter int W = 5
);
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] grant;
    logic         req_any;
`ifdef RR_ENC_REQ_COUNT_EN
    logic [W:0]   req_cnt;

    modport slave (
        input  req, out_ready,
        output out_valid, out_idx, grant, req_any, req_cnt
    );
    modport master (
        output req, out_ready,
        input  out_valid, out_idx, grant, req_any, req_cnt
    );
`else
    modport slave (
        input  req, out_ready,
        output out_valid, out_idx, grant, req_any
    );
    modport master (
        output req, out_ready,
        input  out_valid, out_idx, grant, req_any
    );
`endif
endinterface

// File: rtl/rr_encoder32_5.sv
// Registered round-robin 32->5 encoder with valid/ready output and grant pulse.
// Optional RR_ENC_REQ_COUNT_EN registers the popcount of req on every load.
module rr_encoder32_5 #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           reset,
    rr_encoder32_5_if.slave bus
);

    logic [W-1:0] ptr_r;
    logic [W-1:0] out_idx_r;
    logic         out_valid_r;
    logic [N-1:0] grant_r;
    logic [W-1:0] sel_s;
    logic [N-1:0] hi_mask_s;
    logic [N-1:0] hi_req_s;
    logic [N-1:0] onehot_s;
    logic         req_any_s;
    logic         load_s;

    // Lowest set bit index of vec; zero when vec is empty.
    function automatic logic [W-1:0] first_set(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef RR_ENC_REQ_COUNT_EN
    logic [W:0] req_cnt_r;

    function automatic logic [W:0] popcount(input logic [N-1:0] vec);
        logic [W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + (W+1)'(vec[i]);
        end
        return cnt;
    endfunction
`endif

    assign req_any_s = |bus.req;
    assign load_s    = req_any_s & (~out_valid_r | bus.out_ready);

    // Round-robin pick: prefer set bits at or above ptr, else wrap to the lowest set bit.
    always_comb begin
        hi_mask_s = '0;
        onehot_s  = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask_s[i] = (W'(i) >= ptr_r);
        end
        hi_req_s = bus.req & hi_mask_s;
        if (|hi_req_s) begin
            sel_s = first_set(hi_req_s);
        end else begin
            sel_s = first_set(bus.req);
        end
        onehot_s[sel_s] = 1'b1;
    end

    // Output register, rotation pointer and one-cycle grant pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r       <= '0;
            out_idx_r   <= '0;
            out_valid_r <= 1'b0;
            grant_r     <= '0;
        end else begin
            grant_r <= load_s ? onehot_s : '0;
            if (load_s) begin
                out_idx_r   <= sel_s;
                out_valid_r <= 1'b1;
                ptr_r       <= sel_s + W'(1'b1);
            end else if (out_valid_r && bus.out_ready) begin
                // Accepted with nothing pending: index is kept for observability.
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

`ifdef RR_ENC_REQ_COUNT_EN
    // Popcount snapshot taken alongside each load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cnt_r <= '0;
        end else if (load_s) begin
            req_cnt_r <= popcount(bus.req);
        end else begin
            req_cnt_r <= req_cnt_r;
        end
    end

    assign bus.req_cnt = req_cnt_r;
`endif

    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.grant     = grant_r;
    assign bus.req_any   = req_any_s;

endmodule

// File: tb/tb_rr_encoder32_5.sv
// Directed self-checking bench for rr_encoder32_5 (optionally with RR_ENC_REQ_COUNT_EN).
module tb_rr_encoder32_5;

    logic clk;
    logic reset;
    int   assert_cnt;
    int   fail_cnt;

    rr_encoder32_5_if #(.N(32), .W(5)) bus ();

    rr_encoder32_5 #(.N(32), .W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [4:0] idx,
                             input logic [31:0] gnt);
        check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, vld});
        check_eq({tag, "_idx"},   {27'd0, bus.out_idx},   {27'd0, idx});
        check_eq({tag, "_grant"}, bus.grant, gnt);
    endtask

    logic [4:0]  rr_idx [5];
    logic [31:0] rr_gnt [5];

    initial begin
        assert_cnt    = 0;
        fail_cnt      = 0;
        reset         = 1'b1;
        bus.req       = 32'h0000_0000;
        bus.out_ready = 1'b0;
        rr_idx = '{5'd0, 5'd4, 5'd31, 5'd0, 5'd4};
        rr_gnt = '{32'h0000_0001, 32'h0000_0010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0010};

        step();
        check_out("reset", 1'b0, 5'd0, 32'h0);
        check_eq("reset_req_any", {31'd0, bus.req_any}, 32'd0);
`ifdef RR_ENC_REQ_COUNT_EN
        check_eq("reset_cnt", {26'd0, bus.req_cnt}, 32'd0);
`endif
        reset = 1'b0;

        // Single request from ptr=0
        bus.req = 32'h0000_0400;
        bus.out_ready = 1'b1;
        #1 check_eq("single_req_any", {31'd0, bus.req_any}, 32'd1);
        step();
        check_out("single", 1'b1, 5'd10, 32'h0000_0400);

        // ptr=11 now, so bit 11 wins over bit 0
        bus.req = 32'h0000_0801;
        step();
        check_out("ptr11", 1'b1, 5'd11, 32'h0000_0800);

        bus.req = 32'h0000_0000;
        step();
        check_out("drain1", 1'b0, 5'd11, 32'h0);
        step();
        check_out("idle", 1'b0, 5'd11, 32'h0);

        // ptr=12: only bit below ptr is set -> wrap
        bus.req = 32'h0000_0004;
        step();
        check_out("wrap_low", 1'b1, 5'd2, 32'h0000_0004);
        bus.req = 32'h0000_0084;
        step();
        check_out("skip_below", 1'b1, 5'd7, 32'h0000_0080);

        // ptr=8: all set picks ptr
        bus.req = 32'hFFFF_FFFF;
        step();
        check_out("all_set", 1'b1, 5'd8, 32'h0000_0100);
`ifdef RR_ENC_REQ_COUNT_EN
        check_eq("cnt_all", {26'd0, bus.req_cnt}, 32'd32);
`endif
        bus.req = 32'h0000_0003;
        step();
        check_out("two_low", 1'b1, 5'd0, 32'h0000_0001);
`ifdef RR_ENC_REQ_COUNT_EN
        check_eq("cnt_two", {26'd0, bus.req_cnt}, 32'd2);
`endif

        // ptr=1: load idx 29, then reset mid-cycle
        bus.req = 32'h2000_0000;
        step();
        check_out("pre_reset", 1'b1, 5'd29, 32'h2000_0000);
        #2 reset = 1'b1;
        #1 check_out("mid_reset", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin from ptr=0 with held request, wrapping 31 -> 0
        bus.req = 32'h8000_0011;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("rr%0d", i), 1'b1, rr_idx[i], rr_gnt[i]);
        end

        // Stall: ptr=5, out_idx=4
        bus.out_ready = 1'b0;
        bus.req = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("stall%0d", i), 1'b1, 5'd4, 32'h0);
`ifdef RR_ENC_REQ_COUNT_EN
            check_eq($sformatf("stall_cnt%0d", i), {26'd0, bus.req_cnt}, 32'd3);
`endif
        end
        bus.out_ready = 1'b1;
        step();
        check_out("unstall", 1'b1, 5'd8, 32'h0000_0100);
`ifdef RR_ENC_REQ_COUNT_EN
        check_eq("unstall_cnt", {26'd0, bus.req_cnt}, 32'd1);
`endif

        bus.req = 32'h0000_0000;
        #1 check_eq("drain_req_any", {31'd0, bus.req_any}, 32'd0);
        step();
        check_out("drain2", 1'b0, 5'd8, 32'h0);
`ifdef RR_ENC_REQ_COUNT_EN
        check_eq("drain_cnt", {26'd0, bus.req_cnt}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rr_encoder32_5.md
Name: rr_encoder32_5

Overview:
- Registered round-robin encoder: compresses a 32-bit request vector into a 5-bit index, the inverse of the 5-to-32 one-hot decode used for register-file write select.
- Feeds index producers such as a pending-writeback or interrupt selector into downstream logic expecting a 5-bit register number.
- One-entry output register with valid/ready handshake.
- Grant pulse back to the requester so it can retire the serviced request.

Parameters:
- N, 32, number of request lines; power of two, 2..32.
- W, 5, index width; must equal log2(N).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request vector; any number of bits may be set.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds a valid encoded index.
- out_idx  output  W  encoded index of the selected request.
- grant  output  N  one-hot, one-cycle pulse marking the request captured this cycle.
- req_any  output  1  combinational OR of req.

Behaviour:
- Reset values (async on reset high): out_valid=0, out_idx=0, grant=0, rotation pointer ptr=0.
- State: output register empty (out_valid=0) or full (out_valid=1).
- Load condition: load = req_any & (~out_valid | out_ready).
- Selection: sel = first set bit of req scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
- On load, at the next edge:
  - out_idx <= sel
  - out_valid <= 1
  - ptr <= (sel+1) mod N, W-bit natural wrap, so 31+1 -> 0
  - grant <= one-hot(sel) for exactly one cycle
- On out_valid & out_ready & ~req_any: out_valid <= 0, out_idx holds its last value, ptr unchanged.
- On out_valid & ~out_ready (stall): out_idx, out_valid and ptr hold; grant=0. req changes are ignored until the stall ends.
- Simultaneous accept and new request: back-to-back load with no bubble; one result per cycle sustained.
- Latency: req at edge k -> out_valid/out_idx visible after edge k+1; grant asserted in the same cycle out_valid rises.
- Requester contract: the requester clears the granted bit within one cycle of the grant pulse. If the bit is still set, it stays eligible but is only picked again after all other set bits (fairness via ptr).
- No request dropped while req is held: any set bit is granted within N loads.
- Reset mid-transaction: the pending out_idx is discarded and ptr returns to 0. Reset has priority over load.
- req = 0 with the register empty: outputs hold, no grant.

Optional Feature:
- Macro: RR_ENC_REQ_COUNT_EN.
- When defined:
  - Adds output req_cnt [W:0], the popcount of req, registered on every load.
  - Reset value 0; holds when there is no load.
  - Range 0..N; the value N needs the extra bit.
- When undefined: the port and popcount logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-cycle with out_valid=1 -> out_valid=0, out_idx=0, grant=0 immediately; the next load with req=32'h0000_0001 yields idx 0.
- Single request: req=32'h0000_0400, out_ready=1 -> one cycle later out_valid=1, out_idx=10, grant=32'h0000_0400, ptr=11.
- Round-robin: req held at 32'h8000_0011, out_ready=1 -> out_idx sequence 0, 4, 31, 0, 4, with wrap 31 -> 0.
- Stall: out_valid=1 with out_idx=4, out_ready=0 for 3 cycles, req changed to 32'h0000_0100 -> out_idx stays 4, no grant. Raise out_ready -> out_idx=8 the next cycle.
- Drain: req=0 and out_ready=1 while out_valid=1 -> out_valid=0 next cycle, out_idx unchanged, grant=0.
- With RR_ENC_REQ_COUNT_EN: req=32'hFFFF_FFFF -> req_cnt=32, out_idx=ptr value. With req=32'h0000_0003 -> req_cnt=2.
